// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the 1x3 router datapath register stage.
//   - RTR_DATA_W / RTR_ADDR_W  : default byte and destination-field widths
//   - RTR_ADDR_LSB             : LSB of the destination field inside a header;
//                                the length field sits directly above it
//   - RTR_ADDR_INVALID_BIT     : fill bit of the reserved (invalid) address;
//                                the invalid address is all bits equal to it
//   - dout_sel_e               : decoded source of the next FIFO write byte
// ----------------------------------------------------------------------------
package router_pkg;

  localparam int unsigned RTR_DATA_W           = 8;
  localparam int unsigned RTR_ADDR_W           = 2;
  localparam int unsigned RTR_ADDR_LSB         = 0;
  localparam logic        RTR_ADDR_INVALID_BIT = 1'b1;

  typedef enum logic [1:0] {
    DSEL_KEEP = 2'd0,
    DSEL_HDR  = 2'd1,
    DSEL_DIN  = 2'd2,
    DSEL_HOLD = 2'd3
  } dout_sel_e;

endpackage

// File: rtl/router_parity_acc.sv
// ----------------------------------------------------------------------------
// router_parity_acc
//   Packet parity engine: running XOR of header and payload (internal parity),
//   the received parity byte, and the registered mismatch flag.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   i_clr       in   new packet: clear running parity and error flag
//   i_acc_en    in   fold i_acc_data into the running parity
//   i_acc_data  in   byte to fold
//   i_pp_load   in   capture the received parity byte
//   i_pp_data   in   received parity byte
//   i_cmp       in   compare running parity against received parity
//   o_err       out  registered mismatch flag
// ----------------------------------------------------------------------------
module router_parity_acc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_acc_en,
  input  logic [DATA_W-1:0] i_acc_data,
  input  logic              i_pp_load,
  input  logic [DATA_W-1:0] i_pp_data,
  input  logic              i_cmp,
  output logic              o_err
);

  logic [DATA_W-1:0] r_ip;
  logic [DATA_W-1:0] r_pp;

  // A new packet clear wins over any accumulate, latch or compare in the
  // same cycle; the received parity is always reloaded before it is used.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ip  <= '0;
      r_pp  <= '0;
      o_err <= 1'b0;
    end else if (i_clr) begin
      r_ip  <= '0;
      o_err <= 1'b0;
    end else begin
      if (i_acc_en) begin
        r_ip <= r_ip ^ i_acc_data;
      end
      if (i_pp_load) begin
        r_pp <= i_pp_data;
      end
      if (i_cmp) begin
        o_err <= (r_ip != r_pp);
      end
    end
  end

endmodule

// File: rtl/router_data_reg.sv
// ----------------------------------------------------------------------------
// router_data_reg
//   Datapath register stage behind the router control FSM. Latches the packet
//   header, registers payload bytes toward the addressed output FIFO, parks
//   the byte that arrives while that FIFO is full, and checks packet parity.
//   Optional feature macro: ROUTER_REG_LEN_CHECK_EN adds a payload length
//   check and the len_err output.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-low reset
//   pkt_valid      in   source is driving packet bytes (low on parity byte)
//   data_in        in   source byte
//   fifo_full      in   full flag of the addressed output FIFO
//   detect_add     in   FSM state flag: header decode / new packet
//   lfd_state      in   FSM state flag: load first data (header to FIFO)
//   ld_state       in   FSM state flag: load payload
//   laf_state      in   FSM state flag: load after full (flush held byte)
//   full_state     in   FSM state flag: waiting on a full FIFO
//   rst_int_reg    in   FSM state flag: parity check / internal reset
//   dout           out  byte presented to the FIFO write port
//   parity_done    out  parity byte has been captured
//   low_pkt_valid  out  pkt_valid fell while loading
//   err            out  computed parity differs from received parity
//   len_err        out  (ROUTER_REG_LEN_CHECK_EN only) payload count differs
//                       from the header length field
// ----------------------------------------------------------------------------
module router_data_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = RTR_DATA_W,
  parameter int unsigned ADDR_W = RTR_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
`ifdef ROUTER_REG_LEN_CHECK_EN
  ,
  output logic              len_err
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_INVALID = {ADDR_W{RTR_ADDR_INVALID_BIT}};

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic              r_pd_q;

  logic              w_hdr_load;
  logic              w_pp_from_din;
  logic              w_pp_from_hold;
  logic              w_pp_load;
  logic [DATA_W-1:0] w_pp_data;
  logic              w_acc_en;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_err_cmp;
  dout_sel_e         w_dsel;

  assign w_hdr_load = detect_add && pkt_valid &&
                      (data_in[RTR_ADDR_LSB +: ADDR_W] != ADDR_INVALID);

  // Parity byte arrives either straight from the source, or (when the FIFO
  // was full as it arrived) from the hold register during the flush cycle.
  assign w_pp_from_din  = ld_state && !pkt_valid && !fifo_full;
  assign w_pp_from_hold = laf_state && low_pkt_valid && !parity_done;
  assign w_pp_load      = w_pp_from_din || w_pp_from_hold;
  assign w_pp_data      = w_pp_from_din ? data_in : r_hold;

  // Payload is folded in when sampled in ld_state, even if it is parked in
  // the hold register, so the later flush must not fold it a second time.
  assign w_acc_en   = lfd_state || (ld_state && pkt_valid && !full_state);
  assign w_acc_data = lfd_state ? r_hdr : data_in;

  // Compare one cycle after parity_done rises, when ip and pp are both final.
  assign w_err_cmp = parity_done && !r_pd_q;

  always_comb begin
    w_dsel = DSEL_KEEP;
    if (lfd_state) begin
      w_dsel = DSEL_HDR;
    end else if (ld_state && !fifo_full) begin
      w_dsel = DSEL_DIN;
    end else if (laf_state) begin
      w_dsel = DSEL_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hdr         <= '0;
      r_hold        <= '0;
      r_pd_q        <= 1'b0;
      dout          <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
    end else begin
      r_pd_q <= parity_done;

      if (w_hdr_load) begin
        r_hdr <= data_in;
      end

      if (ld_state && fifo_full) begin
        r_hold <= data_in;
      end

      case (w_dsel)
        DSEL_HDR:  dout <= r_hdr;
        DSEL_DIN:  dout <= data_in;
        DSEL_HOLD: dout <= r_hold;
        default:   dout <= dout;
      endcase

      if (ld_state && !pkt_valid) begin
        low_pkt_valid <= 1'b1;
      end else if (rst_int_reg) begin
        low_pkt_valid <= 1'b0;
      end

      if (detect_add) begin
        parity_done <= 1'b0;
      end else if (w_pp_load) begin
        parity_done <= 1'b1;
      end
    end
  end

  router_parity_acc #(
    .DATA_W (DATA_W)
  ) u_parity_acc (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (detect_add),
    .i_acc_en   (w_acc_en),
    .i_acc_data (w_acc_data),
    .i_pp_load  (w_pp_load),
    .i_pp_data  (w_pp_data),
    .i_cmp      (w_err_cmp),
    .o_err      (err)
  );

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int unsigned CNT_W   = DATA_W - ADDR_W;
  localparam int unsigned LEN_LSB = RTR_ADDR_LSB + ADDR_W;

  logic [CNT_W-1:0] r_len_cnt;
  logic             w_cnt_inc;

  // Payload writes only: a flush of a held parity byte is excluded.
  assign w_cnt_inc = (ld_state && pkt_valid && !fifo_full) ||
                     (laf_state && !low_pkt_valid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_len_cnt <= '0;
      len_err   <= 1'b0;
    end else if (detect_add) begin
      r_len_cnt <= '0;
      len_err   <= 1'b0;
    end else begin
      if (w_cnt_inc) begin
        r_len_cnt <= r_len_cnt + CNT_W'(1);
      end
      // Evaluated on the edge where parity_done is set.
      if (w_pp_load && !parity_done) begin
        len_err <= (r_len_cnt != r_hdr[DATA_W-1:LEN_LSB]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_data_reg.sv
module tb_router_data_reg;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       fifo_full = 1'b0;
  logic       detect_add = 1'b0;
  logic       lfd_state = 1'b0;
  logic       ld_state = 1'b0;
  logic       laf_state = 1'b0;
  logic       full_state = 1'b0;
  logic       rst_int_reg = 1'b0;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       len_err;
`endif

  router_data_reg #(
    .DATA_W (8),
    .ADDR_W (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
`ifdef ROUTER_REG_LEN_CHECK_EN
    ,
    .len_err       (len_err)
`endif
  );

  always #5 clock = ~clock;

  // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}
  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RI   = 6'b000001;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Packet-level reference: expected FIFO byte stream and per-packet verdicts.
  logic [7:0] m_hdr = 8'h00;
  logic [7:0] exp_dout[$];
  logic       exp_err[$];
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       exp_len[$];
`endif
  logic [7:0] pay[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    @(negedge clock);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clock);
    reset = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
    pkt_valid = 1'b0;
    fifo_full = 1'b0;
    data_in   = 8'($urandom);
    for (int i = 1; i < int'(n); i++) @(negedge clock);
    m_hdr = 8'h00;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Sends header, pay[], parity (correct XOR flipped by par_mask).
  // stall_mask bit i parks payload byte i in hold; bit pay.size() parks parity.
  // abort_at >= 0 pulls reset instead of sending payload byte abort_at.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par_mask,
                          input int unsigned stall_mask, input int abort_at);
    logic [7:0] par;
    logic [7:0] pbyte;
    int         n;
    n = pay.size();
    step(S_DA, 1'b1, hdr, 1'b0);
    if (hdr[1:0] != 2'b11) m_hdr = hdr;
    exp_dout.push_back(m_hdr);
    step(S_LFD, 1'b1, 8'($urandom), 1'b0);
    par = m_hdr;
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) begin
        do_reset(1);
        return;
      end
      par = par ^ pay[i];
      exp_dout.push_back(pay[i]);
      if (stall_mask[i]) begin
        step(S_LD,   1'b1, pay[i],       1'b1);
        step(S_FULL, 1'b1, 8'($urandom), 1'b1);
        step(S_LAF,  1'b1, 8'($urandom), 1'b0);
      end else begin
        step(S_LD, 1'b1, pay[i], 1'b0);
      end
    end
    pbyte = par ^ par_mask;
    exp_dout.push_back(pbyte);
    exp_err.push_back(par_mask != 8'h00);
`ifdef ROUTER_REG_LEN_CHECK_EN
    exp_len.push_back(n != int'(m_hdr[7:2]));
`endif
    if (stall_mask[n]) begin
      step(S_LD,   1'b0, pbyte,        1'b1);
      step(S_FULL, 1'b0, 8'($urandom), 1'b1);
      step(S_LAF,  1'b0, 8'($urandom), 1'b0);
    end else begin
      step(S_LD, 1'b0, pbyte, 1'b0);
    end
    step(S_IDLE, 1'b0, 8'($urandom), 1'b0);
    step(S_RI,   1'b0, 8'($urandom), 1'b0);
  endtask

  // Monitor: pops an expected byte on every FIFO write and an expected verdict
  // whenever parity_done rises; checks err one clock later.
  logic pd_prev = 1'b0;
  logic err_pending = 1'b0;
  logic cur_err = 1'b0;

  always @(posedge clock) begin
    logic wr;
    logic rs;
    logic da;
    logic ri;
    wr = lfd_state || (ld_state && !fifo_full) || laf_state;
    rs = !reset;
    da = detect_add;
    ri = rst_int_reg;
    #1;
    if (rs) begin
      chk8("reset_dout", dout, 8'h00);
      chk1("reset_parity_done", parity_done, 1'b0);
      chk1("reset_low_pkt_valid", low_pkt_valid, 1'b0);
      chk1("reset_err", err, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
      chk1("reset_len_err", len_err, 1'b0);
`endif
      err_pending = 1'b0;
      pd_prev     = 1'b0;
    end else begin
      if (wr) begin
        if (exp_dout.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL dout_unexpected: got 0x%02h, expected no write", dout);
        end else begin
          chk8("dout", dout, exp_dout.pop_front());
        end
      end
      if (err_pending) begin
        chk1("err", err, cur_err);
        err_pending = 1'b0;
      end
      if (parity_done && !pd_prev) begin
        if (exp_err.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL parity_done_unexpected: got 1, expected 0");
        end else begin
          cur_err = exp_err.pop_front();
          chk1("err_before_compare", err, 1'b0);
          chk1("low_pkt_valid_at_parity", low_pkt_valid, 1'b1);
`ifdef ROUTER_REG_LEN_CHECK_EN
          chk1("len_err", len_err, exp_len.pop_front());
`endif
          err_pending = 1'b1;
        end
      end
      if (ri) begin
        chk1("low_pkt_valid_cleared", low_pkt_valid, 1'b0);
        chk1("err_stable", err, cur_err);
      end
      if (da) begin
        chk1("parity_done_cleared", parity_done, 1'b0);
        chk1("err_cleared", err, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
        chk1("len_err_cleared", len_err, 1'b0);
`endif
      end
      pd_prev = parity_done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned len;
    int unsigned addr;
    int unsigned n;
    int unsigned sm;
    logic [7:0]  mask;

    do_reset(2);

    pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0F, 8'h00, 0, -1);          // invalid address: header stays 0x00
    send_pkt(8'h0D, 8'h00, 0, -1);          // clean packet, parity 0x0D
    send_pkt(8'h0D, 8'h01, 0, -1);          // corrupt parity 0x0C
    send_pkt(8'h0D, 8'h00, 32'b0010, -1);   // FIFO full on 0x22
    send_pkt(8'h0D, 8'h00, 32'b1000, -1);   // FIFO full on parity byte
    send_pkt(8'h0D, 8'h00, 0, 2);           // reset after two payload bytes
    send_pkt(8'h0D, 8'h00, 0, -1);          // clean packet after reset
    pay = '{8'h11, 8'h22};
    send_pkt(8'h0D, 8'h00, 0, -1);          // short payload

    for (int k = 0; k < 40; k++) begin
      len  = $urandom_range(6, 1);
      addr = $urandom_range(3, 0);
      n    = len;
      if ($urandom_range(4, 0) == 0) n = len + 1;
      else if ($urandom_range(4, 0) == 0 && len > 1) n = len - 1;
      pay.delete();
      for (int i = 0; i < int'(n); i++) pay.push_back(8'($urandom));
      mask = ($urandom_range(9, 0) < 3) ? 8'($urandom_range(255, 1)) : 8'h00;
      sm = 0;
      for (int i = 0; i <= int'(n); i++) begin
        if ($urandom_range(3, 0) == 0) sm = sm | (32'd1 << i);
      end
      send_pkt({6'(len), 2'(addr)}, mask, sm, -1);
    end

    step(S_IDLE, 1'b0, 8'h00, 1'b0);
    step(S_IDLE, 1'b0, 8'h00, 1'b0);
    @(posedge clock);
    #2;
    chk8("dout_queue_drained", 8'(exp_dout.size()), 8'h00);
    chk8("verdict_queue_drained", 8'(exp_err.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
